// File: rtl/op_result_wb.sv
// rtl/op_result_wb.sv - operation result write-back FIFO with valid/ready drain; optional OP_RESULT_WB_DROP_CNT_EN drop counter
module op_result_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW+1:0] wr_entry,
    output logic [DW+1:0] rd_entry
);
    localparam int AW = $clog2(DEPTH);

    logic [DW+1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= wr_entry;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign rd_entry = mem[rptr];
endmodule

module op_result_wb #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_done,
    input  logic [1:0]               op_code,
    input  logic [DW-1:0]            op_result,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DW-1:0]            wb_data,
    output logic [1:0]               wb_code,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
`ifdef OP_RESULT_WB_DROP_CNT_EN
    output logic [7:0]               drop_cnt,
`endif
    input  logic                     ovf_clr
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic {ST_EMPTY, ST_ACTIVE} state_t;

    state_t        state_q;
    state_t        state_d;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          push;
    logic          pop;
    logic          drop;
    logic          overflow_q;
    logic [DW+1:0] head_entry;

    assign full     = (level_q == LW'(DEPTH));
    assign level    = level_q;
    assign wb_valid = (state_q == ST_ACTIVE);
    assign overflow = overflow_q;
    assign wb_code  = head_entry[DW+1:DW];
    assign wb_data  = head_entry[DW-1:0];

    // A full buffer still accepts a completion when the head leaves in the same cycle.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        pop     = 1'b0;
        push    = 1'b0;
        drop    = 1'b0;

        pop  = (state_q == ST_ACTIVE) && wb_ready;
        push = op_done && (!full || pop);
        drop = op_done && full && !pop;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case (state_q)
            ST_EMPTY:  if (push) state_d = ST_ACTIVE;
            ST_ACTIVE: if (pop && !push && (level_q == LW'(1))) state_d = ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef OP_RESULT_WB_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (ovf_clr) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt != 8'hff)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    op_result_wb_queue #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry ({op_code, op_result}),
        .rd_entry (head_entry)
    );
endmodule
